result_bcd_converter: RTL and testbench

- Converts the signed binary result of the arithmetic unit into the packed 7-digit display code vector (`result_digits`) plus a sign flag, which the scanning display driver shows in the RESULT state.
- Sits directly upstream of the display driver.
- Uses a sequential shift-add-3 (double-dabble) engine with a start/busy/done handshake.
- Applies leading-zero blanking and flags out-of-range results.

---
 rtl/result_bcd_converter.sv | 128 ++++++++++++
 tb/tb_result_bcd_converter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Signed binary to 7-digit display code converter using a sequential double-dabble engine.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_BLANK_EN.
module result_bcd_converter #(
    parameter int WIDTH = 32,
    parameter int NDIG  = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    value,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   result_digits,
    output logic                is_result_negative,
    output logic                overflow
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int NB    = 10;
`ifdef BCD_LEADING_BLANK_EN
    localparam logic [4*NDIG-1:0] RST_DIGITS = 28'hBBBBBB0;
`else
    localparam logic [4*NDIG-1:0] RST_DIGITS = 28'h0000000;
`endif
    localparam logic [4*NDIG-1:0] OVF_DIGITS = 28'hBBBBBBE;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_mag;
    logic [4*NB-1:0]     r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_neg, r_ovf;
    logic [WIDTH-1:0]    w_mag;
    logic                w_ovf;
    logic [4*NB-1:0]     w_bcd_adj;
    logic [4*NDIG-1:0]   w_digits;

    // Unsigned magnitude: the most negative input maps to 2^(WIDTH-1) without wrapping.
    assign w_mag = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
    assign w_ovf = 32'(w_mag) > 32'd9999999;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NB; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

`ifdef BCD_LEADING_BLANK_EN
    logic w_lead;
    always_comb begin
        w_digits = r_bcd[4*NDIG-1:0];
        w_lead   = 1'b1;
        for (int i = NDIG-1; i >= 1; i--) begin
            if (w_lead && r_bcd[4*i +: 4] == 4'd0)
                w_digits[4*i +: 4] = 4'hB;
            else
                w_lead = 1'b0;
        end
    end
`else
    assign w_digits = r_bcd[4*NDIG-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag              <= '0;
            r_bcd              <= '0;
            r_cnt              <= '0;
            r_neg              <= 1'b0;
            r_ovf              <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            result_digits      <= RST_DIGITS;
            is_result_negative <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_neg <= value[WIDTH-1];
                        r_mag <= w_mag;
                        r_ovf <= w_ovf;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= (w_bcd_adj << 1) | {{(4*NB-1){1'b0}}, r_mag[WIDTH-1]};
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (r_ovf) begin
                        result_digits      <= OVF_DIGITS;
                        is_result_negative <= 1'b0;
                        overflow           <= 1'b1;
                    end else begin
                        result_digits      <= w_digits;
                        is_result_negative <= r_neg;
                        overflow           <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: scoreboard of expected display codes
// from a division-based decimal model, plus handshake, reset and latency checks.
module tb_result_bcd_converter;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;
`ifdef BCD_LEADING_BLANK_EN
    localparam logic [27:0] RST_D = 28'hBBBBBB0;
`else
    localparam logic [27:0] RST_D = 28'h0000000;
`endif

    typedef struct {
        logic [27:0] d;
        logic        n;
        logic        o;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy, done, is_result_negative, overflow;
    logic [27:0]      result_digits;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t exp_last;

    result_bcd_converter #(.WIDTH(WIDTH), .NDIG(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy), .done(done), .result_digits(result_digits),
        .is_result_negative(is_result_negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input longint v);
        exp_t   e;
        longint m;
        bit     lead;
        m = (v < 0) ? -v : v;
        if (m > 9999999) begin
            e.d = 28'hBBBBBBE; e.n = 1'b0; e.o = 1'b1;
        end else begin
            e.o = 1'b0;
            e.n = (v < 0);
            for (int i = 0; i < 7; i++) begin
                e.d[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
`ifdef BCD_LEADING_BLANK_EN
            lead = 1'b1;
            for (int i = 6; i >= 1; i--) begin
                if (lead && e.d[4*i +: 4] == 4'd0) e.d[4*i +: 4] = 4'hB;
                else lead = 1'b0;
            end
`endif
        end
        return e;
    endfunction

    // Starts one conversion from an edge+1 alignment and waits for done (bounded).
    task automatic drive_conv(input longint v, output int lat, output bit busy_ok, output bit held);
        value = v[WIDTH-1:0];
        start = 1'b1;
        sb.push_back(model(v));
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = -1;
        busy_ok = busy;
        held    = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
            if (!busy) busy_ok = 1'b0;
            if (result_digits !== exp_last.d || overflow !== exp_last.o ||
                is_result_negative !== exp_last.n) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (overflow !== 1'b0 || is_result_negative !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ovf=%b neg=%b want 0 0", overflow, is_result_negative); end
        checks++; if (result_digits !== RST_D) begin
            errors++; $display("FAIL reset_digits got=%h want=%h", result_digits, RST_D); end
    endtask

    task automatic test_convert(input string tag, input longint v);
        int   lat;
        bit   bok, held;
        exp_t e;
        drive_conv(v, lat, bok, held);
        e = sb.pop_front();
        checks++; if (lat !== LAT) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", tag, lat, LAT); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL %s_busy got=0 during conversion want=1", tag); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL %s_hold outputs changed mid-conversion want held", tag); end
        checks++; if (result_digits !== e.d) begin errors++; $display("FAIL %s_digits got=%h want=%h", tag, result_digits, e.d); end
        checks++; if (is_result_negative !== e.n) begin errors++; $display("FAIL %s_sign got=%b want=%b", tag, is_result_negative, e.n); end
        checks++; if (overflow !== e.o) begin errors++; $display("FAIL %s_overflow got=%b want=%b", tag, overflow, e.o); end
        exp_last = e;
    endtask

    task automatic test_reset_mid;
        bit seen;
        value = 32'd1234567;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_hs got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (result_digits !== RST_D || overflow !== 1'b0 || is_result_negative !== 1'b0) begin
            errors++; $display("FAIL midreset_out got=%h ovf=%b neg=%b want=%h 0 0", result_digits, overflow, is_result_negative, RST_D); end
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int n = 0; n < 45; n++) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_nodone got activity=1 want=0"); end
        checks++; if (result_digits !== RST_D) begin
            errors++; $display("FAIL midreset_digits got=%h want=%h", result_digits, RST_D); end
        exp_last.d = RST_D; exp_last.n = 1'b0; exp_last.o = 1'b0;
    endtask

    task automatic test_ignore_start;
        int   ndone, first;
        exp_t e;
        logic [27:0] d_at;
        logic n_at, o_at;
        value = 32'd1234;
        start = 1'b1;
        sb.push_back(model(1234));
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first = -1;
        d_at = '0; n_at = 1'b0; o_at = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            start = (n == 4 || n == 19);
            if (n == 4) value = 32'd999;
            if (done) begin
                ndone++;
                if (first < 0) begin first = n; d_at = result_digits; n_at = is_result_negative; o_at = overflow; end
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_count got=%0d want=1", ndone); end
        checks++; if (first !== LAT) begin errors++; $display("FAIL ignore_latency got=%0d want=%0d", first, LAT); end
        checks++; if (d_at !== e.d || n_at !== e.n || o_at !== e.o) begin
            errors++; $display("FAIL ignore_result got=%h/%b/%b want=%h/%b/%b", d_at, n_at, o_at, e.d, e.n, e.o); end
        exp_last = e;
    endtask

    task automatic test_back_to_back;
        longint vals[3];
        int     idx, last, c;
        bit     held, gap_ok;
        exp_t   e;
        vals[0] = 11; vals[1] = -250; vals[2] = 8888888;
        idx = 0; last = -1; held = 1'b1; gap_ok = 1'b1;
        value = vals[0][WIDTH-1:0];
        start = 1'b1;
        sb.push_back(model(vals[0]));
        @(posedge clk); #1;
        for (c = 1; c <= 3*(LAT+1) + 20 && idx < 3; c++) begin
            @(posedge clk); #1;
            if (done) begin
                e = sb.pop_front();
                if ((last < 0 && c != LAT) || (last >= 0 && c - last != LAT + 1)) gap_ok = 1'b0;
                checks++; if (result_digits !== e.d || is_result_negative !== e.n || overflow !== e.o) begin
                    errors++; $display("FAIL b2b_result%0d got=%h/%b/%b want=%h/%b/%b", idx,
                                       result_digits, is_result_negative, overflow, e.d, e.n, e.o); end
                exp_last = e;
                last = c;
                idx++;
                if (idx < 3) begin
                    value = vals[idx][WIDTH-1:0];
                    sb.push_back(model(vals[idx]));
                end else start = 1'b0;
            end else if (result_digits !== exp_last.d || is_result_negative !== exp_last.n ||
                         overflow !== exp_last.o) held = 1'b0;
        end
        start = 1'b0;
        checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", idx); end
        checks++; if (gap_ok !== 1'b1) begin errors++; $display("FAIL b2b_spacing got irregular want every %0d", LAT+1); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold outputs changed between pulses want held"); end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        exp_last.d = RST_D; exp_last.n = 1'b0; exp_last.o = 1'b0;
        #2;
        test_reset();
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset_mid();
        test_convert("pos305", 305);
        test_convert("neg9999999", -9999999);
        test_convert("zero", 0);
        test_convert("val42", 42);
        test_convert("max_pos", 9999999);
        test_convert("ovf10M", 10000000);
        test_convert("ovf_minint", -64'sd2147483648);
        test_convert("after_ovf7", 7);
        test_convert("neg1", -1);
        test_ignore_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
